// File: rtl/present_pkg.sv
// Shared PRESENT-80 constants, layer functions and key-schedule helpers
// for the round-based decryption core.
package present_pkg;

   localparam int ROUNDS_MAX = 31;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      KEYGEN = 2'd1,
      DEC    = 2'd2
   } fsm_e;

   // Entry i sits at bits [4*i+3:4*i].
   localparam logic [15:0][3:0] SBOX     = 64'h2174_8FE3_DA09_B65C;
   localparam logic [15:0][3:0] INV_SBOX = 64'hA970_364B_D21C_8FE5;

   function automatic logic [63:0] p_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      y[63] = x[63];
      for (int i = 0; i < 63; i++) y[(16 * i) % 63] = x[i];
      return y;
   endfunction

   function automatic logic [63:0] p_layer_inv(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      y[63] = x[63];
      for (int i = 0; i < 63; i++) y[i] = x[(16 * i) % 63];
      return y;
   endfunction

   function automatic logic [63:0] s_layer_inv(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 16; i++) y[4*i +: 4] = INV_SBOX[x[4*i +: 4]];
      return y;
   endfunction

   function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] rc);
      logic [79:0] t;
      t = {k[18:0], k[79:19]};
      t[79:76] = SBOX[t[79:76]];
      t[19:15] = t[19:15] ^ rc;
      return t;
   endfunction

   // Exact undo of key_fwd: the operations run backwards in reverse order.
   function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] rc);
      logic [79:0] t;
      t = k;
      t[19:15] = t[19:15] ^ rc;
      t[79:76] = INV_SBOX[t[79:76]];
      return {t[60:0], t[79:61]};
   endfunction

endpackage

// File: rtl/present_key_sched_step.sv
// One PRESENT-80 key-schedule step, forward or inverse by dir_inv.
module present_key_sched_step
   import present_pkg::*;
(
   input  logic [79:0] key_in,
   input  logic [4:0]  round_idx,
   input  logic        dir_inv,
   output logic [79:0] key_out
);

   always_comb begin
      key_out = dir_inv ? key_inv(key_in, round_idx) : key_fwd(key_in, round_idx);
   end

endmodule

// File: rtl/present_round_dec.sv
// Round-based PRESENT-80 decryption core, one inverse round per clock.
// Optional last-round-key cache: define PRESENT_DEC_KEY_CACHE_EN.
//
// state  | meaning
// IDLE   | waiting for start; round_count = 0
// KEYGEN | running the key schedule forward to K_last
// DEC    | applying inverse rounds while walking the key back
module present_round_dec
   import present_pkg::*;
#(
   parameter int ROUNDS = 31
)
(
   input  logic        clk,
   input  logic        n_reset,
   input  logic        start,
   input  logic [63:0] chiphertext,
   input  logic [79:0] key,
   output logic [63:0] plaintext,
   output logic        done,
   output logic        busy,
   output logic [4:0]  round_count
);

   localparam logic [4:0] RND = 5'(ROUNDS);

   fsm_e        fsm_q, fsm_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [79:0] k_q, k_d;
   logic [63:0] st_q, st_d;
   logic [63:0] pt_q, pt_d;
   logic        done_q, done_d;
   logic [79:0] k_next;
   logic [63:0] st_round;

`ifdef PRESENT_DEC_KEY_CACHE_EN
   logic [79:0] cached_key_q, cached_key_d;
   logic [79:0] cached_klast_q, cached_klast_d;
   logic        cache_valid_q, cache_valid_d;
`endif

   present_key_sched_step u_key_step (
      .key_in    (k_q),
      .round_idx (cnt_q),
      .dir_inv   (fsm_q == DEC),
      .key_out   (k_next)
   );

   always_comb begin
      st_round = s_layer_inv(p_layer_inv(st_q)) ^ k_next[79:16];
   end

   always_comb begin
      fsm_d  = fsm_q;
      cnt_d  = cnt_q;
      k_d    = k_q;
      st_d   = st_q;
      pt_d   = pt_q;
      done_d = 1'b0;
`ifdef PRESENT_DEC_KEY_CACHE_EN
      cached_key_d   = cached_key_q;
      cached_klast_d = cached_klast_q;
      cache_valid_d  = cache_valid_q;
`endif
      case (fsm_q)
         IDLE: begin
            if (start) begin
               k_d   = key;
               st_d  = chiphertext;
               cnt_d = 5'd1;
               fsm_d = KEYGEN;
`ifdef PRESENT_DEC_KEY_CACHE_EN
               if (cache_valid_q && (key == cached_key_q)) begin
                  k_d   = cached_klast_q;
                  st_d  = chiphertext ^ cached_klast_q[79:16];
                  cnt_d = RND;
                  fsm_d = DEC;
               end else begin
                  // The entry is only trusted again once this keygen completes.
                  cache_valid_d = 1'b0;
                  cached_key_d  = key;
               end
`endif
            end
         end
         KEYGEN: begin
            k_d = k_next;
            if (cnt_q == RND) begin
               st_d  = st_q ^ k_next[79:16];
               fsm_d = DEC;
`ifdef PRESENT_DEC_KEY_CACHE_EN
               cached_klast_d = k_next;
               cache_valid_d  = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         DEC: begin
            k_d  = k_next;
            st_d = st_round;
            if (cnt_q == 5'd1) begin
               pt_d   = st_round;
               done_d = 1'b1;
               cnt_d  = 5'd0;
               fsm_d  = IDLE;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         default: begin
            fsm_d = IDLE;
            cnt_d = 5'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         fsm_q  <= IDLE;
         cnt_q  <= 5'd0;
         k_q    <= '0;
         st_q   <= '0;
         pt_q   <= '0;
         done_q <= 1'b0;
      end else begin
         fsm_q  <= fsm_d;
         cnt_q  <= cnt_d;
         k_q    <= k_d;
         st_q   <= st_d;
         pt_q   <= pt_d;
         done_q <= done_d;
      end
   end

`ifdef PRESENT_DEC_KEY_CACHE_EN
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         cached_key_q   <= '0;
         cached_klast_q <= '0;
         cache_valid_q  <= 1'b0;
      end else begin
         cached_key_q   <= cached_key_d;
         cached_klast_q <= cached_klast_d;
         cache_valid_q  <= cache_valid_d;
      end
   end
`endif

   assign plaintext   = pt_q;
   assign done        = done_q;
   assign busy        = (fsm_q != IDLE);
   assign round_count = cnt_q;

endmodule

// File: tb/tb_present_round_dec.sv
// Directed, table-driven bench for present_round_dec using known PRESENT-80
// vectors and an independent encryption model for the loopback case.
module tb_present_round_dec;

   localparam int R = 31;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        start = 1'b0;
   logic [63:0] chiphertext = '0;
   logic [79:0] key = '0;
   logic [63:0] plaintext;
   logic        done;
   logic        busy;
   logic [4:0]  round_count;

   int n_checks = 0;
   int n_fail   = 0;

   present_round_dec #(.ROUNDS(R)) dut (
      .clk         (clk),
      .n_reset     (n_reset),
      .start       (start),
      .chiphertext (chiphertext),
      .key         (key),
      .plaintext   (plaintext),
      .done        (done),
      .busy        (busy),
      .round_count (round_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] tb_sbox(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
         4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
         4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
         4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
      endcase
   endfunction

   function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] k0);
      logic [63:0] s, p;
      logic [79:0] k;
      s = pt;
      k = k0;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ k[79:16];
         for (int j = 0; j < 16; j++) s[4*j +: 4] = tb_sbox(s[4*j +: 4]);
         p = '0;
         p[63] = s[63];
         for (int j = 0; j < 63; j++) p[(16 * j) % 63] = s[j];
         s = p;
         k = {k[18:0], k[79:19]};
         k[79:76] = tb_sbox(k[79:76]);
         k[19:15] = k[19:15] ^ 5'(r);
      end
      return s ^ k[79:16];
   endfunction

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Entered and left on a negedge; leaves in the done cycle.
   task automatic run_dec(input logic [63:0] ct, input logic [79:0] k, input logic [63:0] exp_pt,
                          input int exp_lat, input bit trace, input bit mid_start, input string tag);
      int  n;
      int  exp_rc;
      bit  trace_ok;
      bit  busy_ok;
      chiphertext = ct;
      key = k;
      start = 1'b1;
      step();
      start = 1'b0;
      check({tag, "_busy_after_accept"}, busy, 1);
      n = 0;
      trace_ok = 1'b1;
      busy_ok = 1'b1;
      while (done !== 1'b1 && n < 200) begin
         exp_rc = (n <= R - 1) ? n + 1 : (n <= 2 * R - 1) ? 2 * R - n : 0;
         if (trace && round_count !== 5'(exp_rc)) trace_ok = 1'b0;
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (mid_start && n == 20) begin
            start = 1'b1;
            chiphertext = ~ct;
            key = ~k;
         end else if (mid_start && n == 21) begin
            start = 1'b0;
            chiphertext = ct;
            key = k;
         end
         step();
         n++;
      end
      check({tag, "_latency"}, n, exp_lat);
      check({tag, "_plaintext"}, plaintext, exp_pt);
      check({tag, "_busy_at_done"}, busy, 0);
      check({tag, "_busy_held"}, busy_ok, 1);
      if (trace) begin
         check({tag, "_rc_trace"}, trace_ok, 1);
         check({tag, "_rc_idle"}, round_count, 0);
      end
   endtask

   typedef struct {
      logic [63:0] ct;
      logic [79:0] k;
      logic [63:0] pt;
      bit          trace;
      bit          mid;
   } vec_t;

   localparam logic [63:0] CT_K0_P0 = 64'h5579C1387B228445;
   localparam logic [63:0] CT_KF_P0 = 64'hE72C46C0F5945049;
   localparam logic [63:0] CT_K0_PF = 64'hA112FFC72F68417B;
   localparam logic [63:0] CT_KF_PF = 64'h3333DCD3213210D2;
   localparam logic [79:0] KEY_F    = 80'hFFFFFFFFFFFFFFFFFFFF;
   localparam logic [63:0] LB_PT    = 64'h0123456789ABCDEF;
   localparam logic [79:0] LB_KEY   = 80'h0123456789ABCDEF0123;

   vec_t vecs[4];

   initial begin
      int  n;
      bit  quiet;
      vecs[0] = '{ct: CT_K0_P0, k: 80'h0, pt: 64'h0, trace: 1'b1, mid: 1'b0};
      vecs[1] = '{ct: CT_KF_P0, k: KEY_F, pt: 64'h0, trace: 1'b0, mid: 1'b0};
      vecs[2] = '{ct: CT_K0_PF, k: 80'h0, pt: 64'hFFFFFFFFFFFFFFFF, trace: 1'b0, mid: 1'b0};
      vecs[3] = '{ct: ref_enc(LB_PT, LB_KEY), k: LB_KEY, pt: LB_PT, trace: 1'b1, mid: 1'b1};

      // reset state
      repeat (3) @(negedge clk);
      check("rst_plaintext", plaintext, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_round_count", round_count, 0);
      n_reset = 1'b1;
      step();

      // start held low keeps the core idle
      repeat (3) step();
      check("idle_no_start_busy", busy, 0);

      for (int i = 0; i < 4; i++) begin
         run_dec(vecs[i].ct, vecs[i].k, vecs[i].pt, 2 * R, vecs[i].trace, vecs[i].mid,
                 $sformatf("v%0d", i));
         step();
         check($sformatf("v%0d_done_pulse", i), done, 0);
         check($sformatf("v%0d_pt_hold", i), plaintext, vecs[i].pt);
      end

      // back-to-back: second start issued in the done cycle of the first
      run_dec(CT_K0_PF, 80'h0, 64'hFFFFFFFFFFFFFFFF, 2 * R, 1'b0, 1'b0, "b2b_a");
      run_dec(CT_KF_PF, KEY_F, 64'hFFFFFFFFFFFFFFFF, 2 * R, 1'b0, 1'b0, "b2b_b");
      step();

      // reset in DEC at round_count 10 aborts without a done pulse
      chiphertext = CT_K0_P0;
      key = 80'h0;
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (!(n > R && round_count == 5'd10) && n < 200) begin
         step();
         n++;
      end
      check("abort_reached_r10", round_count, 10);
      check("abort_pt_before", plaintext, 64'hFFFFFFFFFFFFFFFF);
      n_reset = 1'b0;
      #1;
      check("abort_plaintext", plaintext, 0);
      check("abort_done", done, 0);
      check("abort_busy", busy, 0);
      check("abort_round_count", round_count, 0);
      @(negedge clk);
      n_reset = 1'b1;
      quiet = 1'b1;
      for (int c = 0; c < 70; c++) begin
         step();
         if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      end
      check("abort_no_done", quiet, 1);
      run_dec(CT_K0_P0, 80'h0, 64'h0, 2 * R, 1'b1, 1'b0, "post_rst");
      step();

`ifdef PRESENT_DEC_KEY_CACHE_EN
      run_dec(CT_K0_P0, 80'h0, 64'h0, R, 1'b0, 1'b0, "cache_hit1");
      step();
      run_dec(CT_K0_PF, 80'h0, 64'hFFFFFFFFFFFFFFFF, R, 1'b0, 1'b0, "cache_hit2");
      step();
      run_dec(CT_KF_P0, KEY_F, 64'h0, 2 * R, 1'b0, 1'b0, "cache_miss");
      step();
      run_dec(CT_KF_PF, KEY_F, 64'hFFFFFFFFFFFFFFFF, R, 1'b0, 1'b0, "cache_hit3");
      step();
`else
      run_dec(CT_K0_P0, 80'h0, 64'h0, 2 * R, 1'b0, 1'b0, "repeat_key1");
      step();
      run_dec(CT_K0_PF, 80'h0, 64'hFFFFFFFFFFFFFFFF, 2 * R, 1'b0, 1'b0, "repeat_key2");
      step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
